morse_symbol_sequencer: RTL and testbench
=========================================

Name: morse_symbol_sequencer

Overview:
Controller between the dit/dah symbol stream and the character translator. It consumes one 3-bit symbol per bigclk cycle from the symbol-detection machine and assembles dits and dahs into a letter pattern. It emits letter tokens and word-break tokens to the translator over a valid/ready handshake. Upstream cannot stall, so the block owns all buffering, overflow and drop policy.

Parameters:
MAX_ELEMS, 6, maximum dit/dah elements per letter (covers punctuation).
LEN_W, 3, width of length field; must satisfy 2^LEN_W > MAX_ELEMS.

Ports:
bigclk  in  1  system clock, all logic on rising edge
resetn  in  1  synchronous active-low reset, sampled on bigclk rising edge
en  in  1  1 = consume sym this cycle; 0 = sym ignored, handshake still serviced
sym  in  3  0 WAIT, 1 DIT, 2 DAH, 3 GAP, 4 SPACE; 5-7 treated as WAIT
out_valid  out  1  token held on out_* is valid
out_ready  in  1  translator accepts token when out_valid && out_ready
out_space  out  1  1 = word-break token (pattern/len are 0)
out_pattern  out  MAX_ELEMS  element i in bit i, first received in bit 0; dit=0, dah=1; unused bits 0
out_len  out  LEN_W  number of valid elements, 1..MAX_ELEMS for letters
err_overrun  out  1  sticky: a token was dropped because the output slot was full
err_overlong  out  1  one-cycle pulse when an overlong letter is discarded
ovr_clr  in  1  clears err_overrun; set has priority if both occur in the same cycle

Behaviour:
- Clock and reset: one clock, bigclk. Reset is synchronous, active-low on resetn. All state updates on the bigclk rising edge.
- Reset values (resetn=0 at an edge): state IDLE, accumulator and count 0, out_valid 0, out_space 0, out_pattern 0, out_len 0, err_overrun 0, err_overlong 0, space_pending 0. Reset mid-letter discards the partial letter and any held token.
- Internal state: accumulator acc[MAX_ELEMS-1:0], count cnt, one-deep output holding register, space_pending flag, and a last_was_space flag.
- States:
  - IDLE: cnt=0. DIT/DAH -> write bit 0, cnt=1, go to COLLECT. GAP is ignored. SPACE -> enqueue a space token unless last_was_space.
  - COLLECT: DIT/DAH with cnt<MAX_ELEMS -> acc[cnt]=bit, cnt++. DIT/DAH with cnt==MAX_ELEMS -> go to OVERLONG. GAP -> enqueue letter (acc, cnt), go to IDLE. SPACE -> enqueue letter, set space_pending, go to SPACE_PEND. WAIT -> no change.
  - OVERLONG: DIT/DAH/WAIT are ignored. GAP -> pulse err_overlong, clear acc/cnt, go to IDLE. SPACE -> pulse err_overlong, go to IDLE and enqueue a space token.
  - SPACE_PEND: when the slot is free (or freed this cycle), load the space token, clear space_pending, go to IDLE. DIT/DAH arriving here starts a new letter in acc while the space is still pending. GAP arriving here is ignored.
- Enqueue rule:
  - The slot is free if out_valid=0, or if out_valid && out_ready this cycle (accept and reload in the same edge, no bubble).
  - If the slot is not free, the new token is dropped and err_overrun is set. The one exception is the pending space in SPACE_PEND, which waits rather than drops.
- Latency: a token is visible on out_valid the cycle after the GAP/SPACE symbol is sampled.
- Holding register:
  - Contents are stable while out_valid && !out_ready.
  - out_valid deasserts the cycle after acceptance unless a new token loads on the same edge.
- Word-break suppression:
  - last_was_space is set when a space token is enqueued and cleared on any DIT/DAH.
  - Consecutive SPACE symbols produce at most one space token; a SPACE with no prior letter since reset produces none.
- Priority order within one cycle: resetn, then acceptance, then the pending space load, then the new-symbol enqueue.
- When en=0, sym is treated as WAIT.

Optional Feature:
MORSE_ERR_CNT_EN:
- Defined: adds outputs drop_cnt[7:0] and overlong_cnt[7:0]. These are saturating counters (stick at 255) that increment on each dropped token and each err_overlong pulse. Both reset to 0 on resetn and clear on ovr_clr.
- Undefined: these ports and counters are absent, and all other behaviour is identical.

Test Plan:
- Letter "A": sym DIT,WAIT,DAH,GAP with out_ready=1 -> one token, out_pattern=6'b000010, out_len=2, out_space=0, out_valid high exactly 1 cycle after GAP.
- Letter then word break: DIT,DIT,DIT,SPACE with out_ready=0 for 3 cycles, then out_ready=1 -> letter (pattern 0, len 3) accepted first, space token (out_space=1) next cycle, err_overrun stays 0.
- Overlong: 7 DITs then GAP -> no token, err_overlong pulses once, next DAH,GAP yields pattern 1, len 1.
- Overrun: out_ready held 0; "E" (DIT,GAP) then "T" (DAH,GAP) -> E held stable, T dropped, err_overrun=1; ovr_clr clears it.
- Back-to-back accept: token held, out_ready=1 on the same edge a new GAP enqueues -> new token loads with no bubble and no drop.
- Reset mid-letter: DIT,DAH, then resetn=0 for 1 cycle, then GAP -> no token; all outputs 0 after reset.

Source files
------------

// File: rtl/morse_symbol_sequencer.sv
// Assembles dit/dah symbols into letter tokens and word-break tokens behind a one-deep valid/ready slot.
// Optional build macro MORSE_ERR_CNT_EN adds saturating drop_cnt/overlong_cnt error counters.
module morse_symbol_sequencer #(
    parameter int MAX_ELEMS = 6,
    parameter int LEN_W     = 3
) (
    input  logic                 bigclk,
    input  logic                 resetn,
    input  logic                 en,
    input  logic [2:0]           sym,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_space,
    output logic [MAX_ELEMS-1:0] out_pattern,
    output logic [LEN_W-1:0]     out_len,
    output logic                 err_overrun,
    output logic                 err_overlong,
    input  logic                 ovr_clr
`ifdef MORSE_ERR_CNT_EN
    ,
    output logic [7:0]           drop_cnt,
    output logic [7:0]           overlong_cnt
`endif
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_COLLECT,
        S_OVERLONG,
        S_SPACE_PEND
    } state_t;

    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_ELEMS);

    state_t                 state_q, state_d;
    logic [MAX_ELEMS-1:0]   acc_q, acc_d;
    logic [LEN_W-1:0]       cnt_q, cnt_d;
    logic                   out_valid_q, out_valid_d;
    logic                   out_space_q, out_space_d;
    logic [MAX_ELEMS-1:0]   out_pattern_q, out_pattern_d;
    logic [LEN_W-1:0]       out_len_q, out_len_d;
    logic                   err_overrun_q, err_overrun_d;
    logic                   err_overlong_q, err_overlong_d;
    logic                   space_pending_q, space_pending_d;
    logic                   last_was_space_q, last_was_space_d;

    logic is_elem, is_dah, is_gap, is_space;
    logic slot_free, enq_letter, enq_space, sp_load, drop, ovl_pulse;

    always_comb begin
        is_dah   = en && (sym == 3'd2);
        is_elem  = en && ((sym == 3'd1) || (sym == 3'd2));
        is_gap   = en && (sym == 3'd3);
        is_space = en && (sym == 3'd4);

        state_d          = state_q;
        acc_d            = acc_q;
        cnt_d            = cnt_q;
        out_valid_d      = out_valid_q;
        out_space_d      = out_space_q;
        out_pattern_d    = out_pattern_q;
        out_len_d        = out_len_q;
        err_overrun_d    = err_overrun_q;
        space_pending_d  = space_pending_q;
        last_was_space_d = last_was_space_q;
        enq_letter       = 1'b0;
        enq_space        = 1'b0;
        sp_load          = 1'b0;
        drop             = 1'b0;
        ovl_pulse        = 1'b0;

        // Acceptance frees the slot on this same edge, so a reload below needs no bubble.
        slot_free = !out_valid_q || out_ready;
        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (is_elem) begin
                    acc_d    = '0;
                    acc_d[0] = is_dah;
                    cnt_d    = LEN_W'(1);
                    state_d  = S_COLLECT;
                end else if (is_space && !last_was_space_q) begin
                    enq_space = 1'b1;
                end
            end
            S_COLLECT: begin
                if (is_elem) begin
                    if (cnt_q < MAX_LEN) begin
                        acc_d[cnt_q] = is_dah;
                        cnt_d        = cnt_q + LEN_W'(1);
                    end else begin
                        state_d = S_OVERLONG;
                    end
                end else if (is_gap || is_space) begin
                    enq_letter = 1'b1;
                    acc_d      = '0;
                    cnt_d      = '0;
                    if (is_space) begin
                        space_pending_d = 1'b1;
                        state_d         = S_SPACE_PEND;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_OVERLONG: begin
                if (is_gap || is_space) begin
                    ovl_pulse = 1'b1;
                    acc_d     = '0;
                    cnt_d     = '0;
                    enq_space = is_space;
                    state_d   = S_IDLE;
                end
            end
            S_SPACE_PEND: begin
                // A letter may start while the space waits; elements beyond MAX_ELEMS here are ignored.
                if (is_elem && (cnt_q < MAX_LEN)) begin
                    if (cnt_q == '0) begin
                        acc_d = '0;
                    end
                    acc_d[cnt_q] = is_dah;
                    cnt_d        = cnt_q + LEN_W'(1);
                end
                if (slot_free) begin
                    sp_load         = 1'b1;
                    out_valid_d     = 1'b1;
                    out_space_d     = 1'b1;
                    out_pattern_d   = '0;
                    out_len_d       = '0;
                    space_pending_d = 1'b0;
                    state_d         = (cnt_d != '0) ? S_COLLECT : S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (enq_letter || enq_space) begin
            if (slot_free) begin
                out_valid_d   = 1'b1;
                out_space_d   = enq_space;
                out_pattern_d = enq_space ? '0 : acc_q;
                out_len_d     = enq_space ? '0 : cnt_q;
            end else begin
                drop = 1'b1;
            end
        end

        if (enq_space || sp_load) begin
            last_was_space_d = 1'b1;
        end
        if (is_elem) begin
            last_was_space_d = 1'b0;
        end

        if (drop) begin
            err_overrun_d = 1'b1;
        end else if (ovr_clr) begin
            err_overrun_d = 1'b0;
        end
        err_overlong_d = ovl_pulse;
    end

    always_ff @(posedge bigclk) begin
        if (!resetn) begin
            state_q          <= S_IDLE;
            acc_q            <= '0;
            cnt_q            <= '0;
            out_valid_q      <= 1'b0;
            out_space_q      <= 1'b0;
            out_pattern_q    <= '0;
            out_len_q        <= '0;
            err_overrun_q    <= 1'b0;
            err_overlong_q   <= 1'b0;
            space_pending_q  <= 1'b0;
            // No letter yet, so a leading SPACE must not emit a word break.
            last_was_space_q <= 1'b1;
        end else begin
            state_q          <= state_d;
            acc_q            <= acc_d;
            cnt_q            <= cnt_d;
            out_valid_q      <= out_valid_d;
            out_space_q      <= out_space_d;
            out_pattern_q    <= out_pattern_d;
            out_len_q        <= out_len_d;
            err_overrun_q    <= err_overrun_d;
            err_overlong_q   <= err_overlong_d;
            space_pending_q  <= space_pending_d;
            last_was_space_q <= last_was_space_d;
        end
    end

`ifdef MORSE_ERR_CNT_EN
    logic [7:0] drop_cnt_q, drop_cnt_d;
    logic [7:0] overlong_cnt_q, overlong_cnt_d;

    always_comb begin
        drop_cnt_d     = ovr_clr ? 8'd0 : drop_cnt_q;
        overlong_cnt_d = ovr_clr ? 8'd0 : overlong_cnt_q;
        if (drop && (drop_cnt_d != 8'hFF)) begin
            drop_cnt_d = drop_cnt_d + 8'd1;
        end
        if (ovl_pulse && (overlong_cnt_d != 8'hFF)) begin
            overlong_cnt_d = overlong_cnt_d + 8'd1;
        end
    end

    always_ff @(posedge bigclk) begin
        if (!resetn) begin
            drop_cnt_q     <= 8'd0;
            overlong_cnt_q <= 8'd0;
        end else begin
            drop_cnt_q     <= drop_cnt_d;
            overlong_cnt_q <= overlong_cnt_d;
        end
    end

    assign drop_cnt     = drop_cnt_q;
    assign overlong_cnt = overlong_cnt_q;
`endif

    assign out_valid    = out_valid_q;
    assign out_space    = out_space_q;
    assign out_pattern  = out_pattern_q;
    assign out_len      = out_len_q;
    assign err_overrun  = err_overrun_q;
    assign err_overlong = err_overlong_q;

endmodule

// File: tb/tb_morse_symbol_sequencer.sv
// Directed self-checking bench for morse_symbol_sequencer (default build, error counters disabled).
module tb_morse_symbol_sequencer;

    localparam logic [2:0] WAIT  = 3'd0;
    localparam logic [2:0] DIT   = 3'd1;
    localparam logic [2:0] DAH   = 3'd2;
    localparam logic [2:0] GAP   = 3'd3;
    localparam logic [2:0] SPACE = 3'd4;

    logic       bigclk = 1'b0;
    logic       resetn;
    logic       en;
    logic [2:0] sym;
    logic       out_valid;
    logic       out_ready;
    logic       out_space;
    logic [5:0] out_pattern;
    logic [2:0] out_len;
    logic       err_overrun;
    logic       err_overlong;
    logic       ovr_clr;

    int total = 0;
    int bad   = 0;

    morse_symbol_sequencer #(.MAX_ELEMS(6), .LEN_W(3)) dut (
        .bigclk       (bigclk),
        .resetn       (resetn),
        .en           (en),
        .sym          (sym),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_space    (out_space),
        .out_pattern  (out_pattern),
        .out_len      (out_len),
        .err_overrun  (err_overrun),
        .err_overlong (err_overlong),
        .ovr_clr      (ovr_clr)
    );

    always #5 bigclk = ~bigclk;

    task automatic tick();
        @(posedge bigclk);
        #1;
    endtask

    task automatic send(input logic [2:0] s);
        sym = s;
        tick();
        sym = WAIT;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
        $display("check %-22s observed=%0h expected=%0h", tag, got, exp);
    endtask

    task automatic chk_token(input string tag, input logic v, input logic sp,
                             input logic [5:0] pat, input logic [2:0] len);
        chk({tag, ".valid"},   32'(out_valid),   32'(v));
        chk({tag, ".space"},   32'(out_space),   32'(sp));
        chk({tag, ".pattern"}, 32'(out_pattern), 32'(pat));
        chk({tag, ".len"},     32'(out_len),     32'(len));
    endtask

    initial begin
        resetn = 1'b0; en = 1'b1; sym = WAIT; out_ready = 1'b0; ovr_clr = 1'b0;
        tick(); tick();
        chk_token("reset", 1'b0, 1'b0, 6'd0, 3'd0);
        chk("reset.overrun",  32'(err_overrun),  32'd0);
        chk("reset.overlong", 32'(err_overlong), 32'd0);
        resetn = 1'b1;

        // Leading SPACE with no letter since reset gives no token
        out_ready = 1'b1;
        send(SPACE);
        chk("lead_space.valid", 32'(out_valid), 32'd0);

        // en=0 masks a DIT, so the following GAP in IDLE emits nothing
        en = 1'b0; send(DIT); en = 1'b1;
        send(GAP);
        chk("en_mask.valid", 32'(out_valid), 32'd0);

        // Letter A: dit, dah -> pattern 000010, len 2, one cycle after GAP
        send(DIT); send(WAIT); send(DAH);
        chk("A.pre_gap.valid", 32'(out_valid), 32'd0);
        send(GAP);
        chk_token("A", 1'b1, 1'b0, 6'b000010, 3'd2);
        tick();
        chk("A.after_accept.valid", 32'(out_valid), 32'd0);

        // Letter S then word break with the translator stalled
        out_ready = 1'b0;
        send(DIT); send(DIT); send(DIT); send(SPACE);
        chk_token("S", 1'b1, 1'b0, 6'd0, 3'd3);
        tick(); tick();
        chk_token("S.held", 1'b1, 1'b0, 6'd0, 3'd3);
        out_ready = 1'b1;
        tick();
        chk_token("wordbreak", 1'b1, 1'b1, 6'd0, 3'd0);
        tick();
        chk("wordbreak.accepted", 32'(out_valid), 32'd0);
        chk("wordbreak.overrun",  32'(err_overrun), 32'd0);
        send(SPACE);
        chk("dup_space.valid", 32'(out_valid), 32'd0);

        // Overlong: seven dits then GAP discards the letter
        for (int i = 0; i < 7; i++) send(DIT);
        send(GAP);
        chk("overlong.pulse", 32'(err_overlong), 32'd1);
        chk("overlong.valid", 32'(out_valid), 32'd0);
        tick();
        chk("overlong.pulse_end", 32'(err_overlong), 32'd0);
        send(DAH); send(GAP);
        chk_token("T_after_overlong", 1'b1, 1'b0, 6'd1, 3'd1);
        tick();

        // Overrun: E held, T dropped
        out_ready = 1'b0;
        send(DIT); send(GAP);
        chk_token("E", 1'b1, 1'b0, 6'd0, 3'd1);
        send(DAH); send(GAP);
        chk_token("E.stable", 1'b1, 1'b0, 6'd0, 3'd1);
        chk("overrun.set", 32'(err_overrun), 32'd1);
        ovr_clr = 1'b1; tick(); ovr_clr = 1'b0;
        chk("overrun.cleared", 32'(err_overrun), 32'd0);

        // Back-to-back: accept E on the same edge that T loads
        send(DAH);
        out_ready = 1'b1;
        send(GAP);
        chk_token("T_b2b", 1'b1, 1'b0, 6'd1, 3'd1);
        chk("b2b.overrun", 32'(err_overrun), 32'd0);
        tick();
        chk("b2b.accepted", 32'(out_valid), 32'd0);

        // Reset mid-letter drops the partial letter
        out_ready = 1'b0;
        send(DIT); send(DAH);
        resetn = 1'b0; tick(); resetn = 1'b1;
        chk_token("midreset", 1'b0, 1'b0, 6'd0, 3'd0);
        send(GAP);
        chk("midreset.gap.valid", 32'(out_valid), 32'd0);
        chk("midreset.overrun",   32'(err_overrun), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
